uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx.sv | 164 ++++++++++++++++
 tb/tb_uart_rx.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop rx synchronizer, mid-bit sampling FSM, and a
// first-word-fall-through receive FIFO with sticky frame/overrun error flags.
module uart_rx #(
  parameter int CLK_RATE   = 10_000_000,
  parameter int BAUD       = 9600,
  parameter int FIFO_DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  input  logic       rd_en,
  input  logic       clr_err,
  output logic [7:0] rd_data,
  output logic       empty,
  output logic       full,
  output logic       frame_err,
  output logic       overrun
);

  localparam int DIV  = CLK_RATE / BAUD;
  localparam int HALF = DIV / 2;
  localparam int CW   = $clog2(DIV);
  localparam int AW   = $clog2(FIFO_DEPTH);

  localparam logic [CW-1:0] DIV_M1  = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
  localparam logic [AW:0]   DEPTH   = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state_q, state_n;
  logic [CW-1:0] cnt_q, cnt_n;
  logic [2:0]    idx_q, idx_n;
  logic [7:0]    sh_q, sh_n;
  logic          rx_meta, rx_sync, rx_prev;
  logic          push_req, ferr_set;

  // Synchronizer resets to the idle level so reset release never looks like a start edge.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      idx_q   <= idx_n;
      sh_q    <= sh_n;
    end
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_n  = state_q;
    cnt_n    = cnt_q;
    idx_n    = idx_q;
    sh_n     = sh_q;
    push_req = 1'b0;
    ferr_set = 1'b0;
    case (state_q)
      IDLE: begin
        // Falling edge only: a line held low after a framing error must go high first.
        if (rx_prev && !rx_sync) begin
          state_n = START;
          cnt_n   = HALF_M1;
        end
      end
      START: begin
        if (cnt_q == '0) begin
          if (!rx_sync) begin
            state_n = DATA;
            cnt_n   = DIV_M1;
            idx_n   = '0;
          end else begin
            state_n = IDLE;
          end
        end else begin
          cnt_n = cnt_q - 1'b1;
        end
      end
      DATA: begin
        if (cnt_q == '0) begin
          sh_n  = {rx_sync, sh_q[7:1]};
          cnt_n = DIV_M1;
          if (idx_q == 3'd7) state_n = STOP;
          else               idx_n   = idx_q + 1'b1;
        end else begin
          cnt_n = cnt_q - 1'b1;
        end
      end
      STOP: begin
        if (cnt_q == '0) begin
          push_req = rx_sync;
          ferr_set = !rx_sync;
          state_n  = IDLE;
        end else begin
          cnt_n = cnt_q - 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == DEPTH);
  assign do_pop  = rd_en && !empty;
  // A pop on a full FIFO frees the slot the same cycle, so the push still lands.
  assign do_push = push_req && (!full || rd_en);
  assign rd_data = empty ? 8'h00 : mem[rd_ptr];

  // NOTE: storage is not reset; only pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= sh_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Setting an error has priority over a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (ferr_set)     frame_err <= 1'b1;
      else if (clr_err) frame_err <= 1'b0;
      if (push_req && full && !rd_en) overrun <= 1'b1;
      else if (clr_err)               overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed frames plus random traffic checked
// against a queue-based model of the receive FIFO and sticky error flags.
module tb_uart_rx;

  localparam int CLK_RATE = 1_000_000;
  localparam int BAUD     = 62_500;
  localparam int DEPTH    = 8;
  localparam int DIV      = CLK_RATE / BAUD;
  localparam int HALF     = DIV / 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic       rd_en = 1'b0;
  logic       clr_err = 1'b0;
  logic [7:0] rd_data;
  logic       empty, full, frame_err, overrun;

  int total = 0;
  int bad = 0;

  logic [7:0] q[$];
  logic       m_ferr = 1'b0;
  logic       m_ovr = 1'b0;

  uart_rx #(.CLK_RATE(CLK_RATE), .BAUD(BAUD), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx), .rd_en(rd_en), .clr_err(clr_err),
    .rd_data(rd_data), .empty(empty), .full(full),
    .frame_err(frame_err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string tag);
    check({tag, ".empty"}, empty, q.size() == 0);
    check({tag, ".full"}, full, q.size() == DEPTH);
    check({tag, ".frame_err"}, frame_err, m_ferr);
    check({tag, ".overrun"}, overrun, m_ovr);
    if (q.size() > 0) check({tag, ".rd_data"}, rd_data, q[0]);
  endtask

  // One 8N1 frame; optionally pulses rd_en on exactly the stop-sample cycle.
  task automatic send_byte(input logic [7:0] b, input logic stop, input bit pop_at_stop);
    logic [9:0] bits;
    bit popped;
    bits = {stop, b, 1'b0};
    for (int k = 0; k < 10; k++) begin
      rx = bits[k];
      for (int j = 1; j <= DIV; j++) begin
        if (k == 9 && j == HALF + 3) begin
          check("pre_stop.empty", empty, q.size() == 0);
          rd_en = pop_at_stop;
        end
        tick;
        if (k == 9 && j == HALF + 3) begin
          rd_en = 1'b0;
          popped = pop_at_stop && q.size() > 0;
          if (popped) void'(q.pop_front());
          if (!stop) m_ferr = 1'b1;
          else if (q.size() < DEPTH) q.push_back(b);
          else m_ovr = 1'b1;
          check_state("stop_sample");
        end
      end
    end
    rx = 1'b1;
    tick;
    tick;
  endtask

  task automatic pop_one;
    if (q.size() > 0) check("pop.rd_data", rd_data, q[0]);
    rd_en = 1'b1;
    tick;
    rd_en = 1'b0;
    if (q.size() > 0) void'(q.pop_front());
    check_state("after_pop");
  endtask

  task automatic clear_errors;
    clr_err = 1'b1;
    tick;
    clr_err = 1'b0;
    m_ferr = 1'b0;
    m_ovr = 1'b0;
    check_state("after_clr");
  endtask

  initial begin
    logic [9:0] bits;
    int glen;

    #1;
    check("reset.empty", empty, 1'b1);
    check("reset.full", full, 1'b0);
    check("reset.frame_err", frame_err, 1'b0);
    check("reset.overrun", overrun, 1'b0);
    check("reset.rd_data", rd_data, 8'h00);
    repeat (3) tick;
    rst_n = 1'b1;
    tick;
    check_state("post_reset");

    send_byte(8'hA5, 1'b1, 1'b0);
    pop_one();

    send_byte(8'h55, 1'b0, 1'b0);
    clear_errors();

    glen = $urandom_range(1, HALF - 2);
    rx = 1'b0;
    repeat (glen) tick;
    rx = 1'b1;
    repeat (2 * DIV) tick;
    check_state("glitch");
    send_byte(8'($urandom), 1'b1, 1'b0);
    pop_one();

    for (int i = 0; i < 9; i++) send_byte(8'(i), 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) pop_one();
    pop_one();
    clear_errors();

    for (int i = 0; i < DEPTH; i++) send_byte(8'($urandom), 1'b1, 1'b0);
    send_byte(8'h3C, 1'b1, 1'b1);
    for (int i = 0; i < DEPTH; i++) pop_one();

    bits = {1'b1, 8'hFF, 1'b0};
    for (int k = 0; k < 5; k++) begin
      rx = bits[k];
      repeat ((k == 4) ? DIV / 2 : DIV) tick;
    end
    rst_n = 1'b0;
    #1;
    q.delete();
    m_ferr = 1'b0;
    m_ovr = 1'b0;
    check("midreset.empty", empty, 1'b1);
    check("midreset.rd_data", rd_data, 8'h00);
    rx = 1'b1;
    tick;
    tick;
    rst_n = 1'b1;
    send_byte(8'h81, 1'b1, 1'b0);
    pop_one();

    for (int it = 0; it < 24; it++) begin
      send_byte(8'($urandom), ($urandom_range(0, 4) != 0), ($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 2) == 0) pop_one();
      if ($urandom_range(0, 5) == 0) clear_errors();
    end
    while (q.size() > 0) pop_one();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
